// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline controller.
// FSM state encoding, index and counter widths, counter helper.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 4;
  localparam int CNT_W     = 16;
  localparam int WAIT_W    = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational RAW hazard detection for the instruction in ID.
// FWD_EN selects full EXE/MEM interlock or load-use only.
module hazard_unit
  import pipe_ctrl_pkg::*;
#(
  parameter bit FWD_EN = 1'b0
) (
  input  logic [REG_IDX_W-1:0] i_src1,
  input  logic [REG_IDX_W-1:0] i_src2,
  input  logic                 i_use_rn,
  input  logic                 i_two_src,
  input  logic [REG_IDX_W-1:0] i_exe_dest,
  input  logic                 i_exe_wb_en,
  input  logic                 i_exe_mem_read,
  input  logic [REG_IDX_W-1:0] i_mem_dest,
  input  logic                 i_mem_wb_en,
  output logic                 o_hazard
);

  logic w_exe_hit;
  logic w_mem_hit;
  logic w_raw;
  logic w_ld_use;

  assign w_exe_hit = (i_use_rn  && (i_exe_dest == i_src1))
                  || (i_two_src && (i_exe_dest == i_src2));
  assign w_mem_hit = (i_use_rn  && (i_mem_dest == i_src1))
                  || (i_two_src && (i_mem_dest == i_src2));

  assign w_raw    = (i_exe_wb_en && w_exe_hit)
                 || (i_mem_wb_en && w_mem_hit);
  assign w_ld_use = i_exe_mem_read && w_exe_hit;

  assign o_hazard = FWD_EN ? w_ld_use : w_raw;

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline stall/flush control with SRAM wait FSM
// and saturating stall/flush performance counters.
module pipeline_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int SRAM_WAIT = 5,
  parameter bit FWD_EN    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic                 id_use_rn,
  input  logic                 id_two_src,
  input  logic [REG_IDX_W-1:0] exe_dest,
  input  logic                 exe_wb_en,
  input  logic                 exe_mem_read,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic                 mem_wb_en,
  input  logic                 branch_taken,
  input  logic                 mem_req,
  output logic                 freeze_if,
  output logic                 bubble_id,
  output logic                 flush_if_id,
  output logic                 flush_id_exe,
  output logic                 stall_pipe,
  output logic                 mem_ready,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  // Busy cycles between the request cycle and the ready cycle.
  localparam logic [WAIT_W-1:0] LOAD = WAIT_W'(SRAM_WAIT - 2);

  state_e            r_state;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_hazard;
  logic w_stall;
  logic w_flush;
  logic w_bubble;
  logic w_freeze;

  hazard_unit #(
    .FWD_EN(FWD_EN)
  ) u_hazard (
    .i_src1        (id_src1),
    .i_src2        (id_src2),
    .i_use_rn      (id_use_rn),
    .i_two_src     (id_two_src),
    .i_exe_dest    (exe_dest),
    .i_exe_wb_en   (exe_wb_en),
    .i_exe_mem_read(exe_mem_read),
    .i_mem_dest    (mem_dest),
    .i_mem_wb_en   (mem_wb_en),
    .o_hazard      (w_hazard)
  );

  // Reset gates every output so it takes effect without a clock.
  assign w_stall  = !rst && ((r_state == IDLE && mem_req)
                          || r_state == MEM_BUSY);
  assign w_flush  = !rst && !w_stall && branch_taken;
  assign w_bubble = !rst && !w_stall && !branch_taken
                 && w_hazard;
  assign w_freeze = w_stall || w_bubble;

  assign freeze_if    = w_freeze;
  assign bubble_id    = w_bubble;
  assign flush_if_id  = w_flush;
  assign flush_id_exe = w_flush;
  assign stall_pipe   = w_stall;
  assign mem_ready    = !rst && (r_state == MEM_DONE);
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

  // SRAM access FSM; r_wait holds the remaining busy cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_wait  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_req) begin
            r_state <= (LOAD == '0) ? MEM_DONE : MEM_BUSY;
            r_wait  <= LOAD;
          end
        end
        MEM_BUSY: begin
          if (!mem_req) begin
            r_state <= IDLE;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait - WAIT_W'(1);
            if (r_wait == WAIT_W'(1)) begin
              r_state <= MEM_DONE;
            end
          end
        end
        MEM_DONE: begin
          r_state <= IDLE;
          r_wait  <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_wait  <= '0;
        end
      endcase
    end
  end

  // Saturating counts of frozen and flushed cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_freeze) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
      if (w_flush) begin
        r_flush_cnt <= sat_inc(r_flush_cnt);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed scoreboard bench for pipeline_controller,
// one instance per forwarding configuration.
module tb_pipeline_controller;

  localparam logic [5:0] O_NONE  = 6'b000000;
  localparam logic [5:0] O_STALL = 6'b100010;
  localparam logic [5:0] O_HAZ   = 6'b110000;
  localparam logic [5:0] O_BR    = 6'b001100;
  localparam logic [5:0] O_RDY   = 6'b000001;
  localparam logic [5:0] O_BRRDY = 6'b001101;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1;
  logic [3:0] id_src2;
  logic       id_use_rn;
  logic       id_two_src;
  logic [3:0] exe_dest;
  logic       exe_wb_en;
  logic       exe_mem_read;
  logic [3:0] mem_dest;
  logic       mem_wb_en;
  logic       branch_taken;
  logic       mem_req;

  logic        d0_freeze, d0_bubble, d0_fif, d0_fie;
  logic        d0_stall, d0_ready;
  logic [15:0] d0_scnt, d0_fcnt;
  logic        d1_freeze, d1_bubble, d1_fif, d1_fie;
  logic        d1_stall, d1_ready;
  logic [15:0] d1_scnt, d1_fcnt;

  typedef struct {
    string       tag;
    int          d;
    int          kind;
    logic [15:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipeline_controller #(.SRAM_WAIT(5), .FWD_EN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_use_rn(id_use_rn), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_req(mem_req),
    .freeze_if(d0_freeze), .bubble_id(d0_bubble),
    .flush_if_id(d0_fif), .flush_id_exe(d0_fie),
    .stall_pipe(d0_stall), .mem_ready(d0_ready),
    .stall_cnt(d0_scnt), .flush_cnt(d0_fcnt)
  );

  pipeline_controller #(.SRAM_WAIT(5), .FWD_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_use_rn(id_use_rn), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_req(mem_req),
    .freeze_if(d1_freeze), .bubble_id(d1_bubble),
    .flush_if_id(d1_fif), .flush_id_exe(d1_fie),
    .stall_pipe(d1_stall), .mem_ready(d1_ready),
    .stall_cnt(d1_scnt), .flush_cnt(d1_fcnt)
  );

  function automatic logic [15:0] observe(input int d, input int kind);
    logic [5:0] o;
    if (d == 0) begin
      o = {d0_freeze, d0_bubble, d0_fif, d0_fie, d0_stall, d0_ready};
      if (kind == 1) return d0_scnt;
      if (kind == 2) return d0_fcnt;
    end else begin
      o = {d1_freeze, d1_bubble, d1_fif, d1_fie, d1_stall, d1_ready};
      if (kind == 1) return d1_scnt;
      if (kind == 2) return d1_fcnt;
    end
    return {10'd0, o};
  endfunction

  task automatic push(input string tag, input int d, input int kind,
                      input logic [15:0] v);
    exp_t e;
    e.tag  = tag;
    e.d    = d;
    e.kind = kind;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic ex_o(input string tag, input int d, input logic [5:0] o);
    push(tag, d, 0, {10'd0, o});
  endtask

  task automatic ex_sc(input string tag, input int d, input logic [15:0] v);
    push(tag, d, 1, v);
  endtask

  task automatic ex_fc(input string tag, input int d, input logic [15:0] v);
    push(tag, d, 2, v);
  endtask

  task automatic drain();
    exp_t        e;
    logic [15:0] act;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = observe(e.d, e.kind);
      checks++;
      assert (act === e.val) else begin
        errors++;
        $error("FAIL %s dut%0d kind%0d got %h expected %h",
               e.tag, e.d, e.kind, act, e.val);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_src1      = '0;
    id_src2      = '0;
    id_use_rn    = 1'b0;
    id_two_src   = 1'b0;
    exe_dest     = '0;
    exe_wb_en    = 1'b0;
    exe_mem_read = 1'b0;
    mem_dest     = '0;
    mem_wb_en    = 1'b0;
    branch_taken = 1'b0;
    mem_req      = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    ex_o("rst_o", 0, O_NONE);
    ex_o("rst_o", 1, O_NONE);
    ex_sc("rst_sc", 0, 16'h0);
    ex_fc("rst_fc", 0, 16'h0);
    tick();
    rst = 1'b0;
  endtask

  task automatic set_exe_haz();
    exe_wb_en = 1'b1;
    exe_dest  = 4'd3;
    id_src1   = 4'd3;
    id_use_rn = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    clr();
    #1;
    // reset forces outputs low despite active inputs
    rst = 1'b1;
    set_exe_haz();
    mem_req      = 1'b1;
    branch_taken = 1'b1;
    #1;
    ex_o("rst_force", 0, O_NONE);
    ex_o("rst_force", 1, O_NONE);
    ex_sc("rst_sc", 0, 16'h0);
    ex_fc("rst_fc", 1, 16'h0);
    tick();
    clr();
    rst = 1'b0;

    // SRAM access latency
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ex_o("mem_stall", 0, O_STALL);
      tick();
    end
    mem_req = 1'b0;
    ex_o("mem_ready", 0, O_RDY);
    ex_o("mem_ready", 1, O_RDY);
    tick();
    ex_o("mem_idle", 0, O_NONE);
    ex_sc("mem_sc", 0, 16'd4);
    ex_sc("mem_sc", 1, 16'd4);
    ex_fc("mem_fc", 0, 16'd0);
    tick();

    // abort when mem_req drops while busy
    do_reset();
    mem_req = 1'b1;
    ex_o("abort_c0", 0, O_STALL);
    tick();
    ex_o("abort_c1", 0, O_STALL);
    tick();
    mem_req = 1'b0;
    ex_o("abort_c2", 0, O_STALL);
    tick();
    ex_o("abort_c3", 0, O_NONE);
    tick();
    ex_o("abort_c4", 0, O_NONE);
    tick();

    // RAW hazards without forwarding
    do_reset();
    set_exe_haz();
    ex_o("raw_exe", 0, O_HAZ);
    ex_o("raw_exe_fwd", 1, O_NONE);
    tick();
    id_use_rn = 1'b0;
    ex_o("raw_no_rn", 0, O_NONE);
    tick();
    id_use_rn = 1'b1;
    exe_wb_en = 1'b0;
    ex_o("raw_no_wb", 0, O_NONE);
    tick();
    id_use_rn  = 1'b0;
    mem_wb_en  = 1'b1;
    mem_dest   = 4'd5;
    id_src2    = 4'd5;
    id_two_src = 1'b1;
    ex_o("raw_mem", 0, O_HAZ);
    ex_o("raw_mem_fwd", 1, O_NONE);
    tick();
    clr();
    exe_wb_en = 1'b1;
    exe_dest  = 4'd15;
    id_src1   = 4'd15;
    id_use_rn = 1'b1;
    ex_o("raw_r15", 0, O_HAZ);
    tick();
    clr();
    ex_o("raw_end", 0, O_NONE);
    ex_sc("raw_sc", 0, 16'd3);
    tick();

    // branch beats hazard
    do_reset();
    set_exe_haz();
    branch_taken = 1'b1;
    ex_o("br_haz", 0, O_BR);
    ex_o("br_haz", 1, O_BR);
    tick();
    branch_taken = 1'b0;
    ex_o("br_after", 0, O_HAZ);
    ex_fc("br_fc", 0, 16'd1);
    ex_sc("br_sc", 0, 16'd0);
    tick();

    // branch held during SRAM access
    do_reset();
    mem_req      = 1'b1;
    branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ex_o("brmem_stall", 0, O_STALL);
      ex_fc("brmem_fc", 0, 16'd0);
      tick();
    end
    mem_req = 1'b0;
    ex_o("brmem_done", 0, O_BRRDY);
    tick();
    branch_taken = 1'b0;
    ex_o("brmem_idle", 0, O_NONE);
    ex_fc("brmem_fc", 0, 16'd1);
    ex_sc("brmem_sc", 0, 16'd4);
    tick();

    // load-use with forwarding
    do_reset();
    exe_mem_read = 1'b1;
    exe_wb_en    = 1'b1;
    exe_dest     = 4'd7;
    id_src2      = 4'd7;
    id_two_src   = 1'b1;
    ex_o("lu_hit", 1, O_HAZ);
    ex_o("lu_hit_nofwd", 0, O_HAZ);
    tick();
    exe_mem_read = 1'b0;
    ex_o("lu_noload", 1, O_NONE);
    ex_o("lu_noload_nofwd", 0, O_HAZ);
    tick();
    exe_mem_read = 1'b1;
    id_two_src   = 1'b0;
    ex_o("lu_nosrc", 1, O_NONE);
    ex_o("lu_nosrc_nofwd", 0, O_NONE);
    tick();
    exe_mem_read = 1'b0;
    exe_wb_en    = 1'b0;
    mem_wb_en    = 1'b1;
    mem_dest     = 4'd7;
    id_two_src   = 1'b1;
    ex_o("lu_memonly", 1, O_NONE);
    ex_o("lu_memonly_nofwd", 0, O_HAZ);
    tick();

    // reset in the second busy cycle
    do_reset();
    mem_req = 1'b1;
    ex_o("rb_c0", 0, O_STALL);
    tick();
    ex_o("rb_c1", 0, O_STALL);
    tick();
    ex_o("rb_c2", 0, O_STALL);
    drain();
    rst = 1'b1;
    #1;
    ex_o("rb_now", 0, O_NONE);
    ex_sc("rb_sc", 0, 16'd0);
    drain();
    ex_o("rb_hold", 0, O_NONE);
    tick();
    rst     = 1'b0;
    mem_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ex_o("rb_noready", 0, O_NONE);
      tick();
    end

    // stall counter saturation
    set_exe_haz();
    for (int i = 0; i < 65535; i++) begin
      tick();
    end
    ex_sc("sat_full", 0, 16'hFFFF);
    drain();
    tick();
    ex_sc("sat_hold", 0, 16'hFFFF);
    ex_o("sat_haz", 0, O_HAZ);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
